// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage IEEE-754-style floating-point multiplier.
// S1 unpacks/classifies and sums exponents, S2 multiplies mantissas, S3
// normalises, rounds to nearest-even, packs and raises flags. Valid/ready
// flow control stalls every stage together when the output is held.
// Optional sticky flag accumulator: define FP_MUL_STICKY_FLAGS_EN to add
// ClearFlags / StickyFlags.
module fp_mul_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [EXP_W+FRAC_W:0]   Operand1,
    input  logic [EXP_W+FRAC_W:0]   Operand2,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [EXP_W+FRAC_W:0]   Result,
    output logic [3:0]              Flags
`ifdef FP_MUL_STICKY_FLAGS_EN
    ,
    input  logic                    ClearFlags,
    output logic [3:0]              StickyFlags
`endif
);

    localparam int DATA_W = 1 + EXP_W + FRAC_W;
    localparam int BIAS   = 2**(EXP_W-1) - 1;
    localparam int MANT_W = FRAC_W + 1;
    localparam int PROD_W = 2 * MANT_W;
    localparam int EXP_SW = EXP_W + 2;

    localparam logic signed [EXP_SW-1:0] BIAS_S = EXP_SW'(BIAS);
    localparam logic signed [EXP_SW-1:0] EMAX_S = EXP_SW'(2**EXP_W - 1);
    localparam logic [DATA_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    // Pipeline advance: every stage moves when the output slot is free or taken.
    logic adv;

    // S1 registers
    logic                     v1_d, v1_q;
    logic                     sign1_d, sign1_q;
    logic signed [EXP_SW-1:0] exp1_d, exp1_q;
    logic [MANT_W-1:0]        mant_a1_d, mant_a1_q;
    logic [MANT_W-1:0]        mant_b1_d, mant_b1_q;
    logic                     spc1_d, spc1_q;
    logic [DATA_W-1:0]        spc_res1_d, spc_res1_q;
    logic [3:0]               spc_flg1_d, spc_flg1_q;

    // S2 registers
    logic                     v2_d, v2_q;
    logic                     sign2_d, sign2_q;
    logic signed [EXP_SW-1:0] exp2_d, exp2_q;
    logic [PROD_W-1:0]        prod2_d, prod2_q;
    logic                     spc2_d, spc2_q;
    logic [DATA_W-1:0]        spc_res2_d, spc_res2_q;
    logic [3:0]               spc_flg2_d, spc_flg2_q;

    // S3 registers (drive the outputs)
    logic                     v3_d, v3_q;
    logic [DATA_W-1:0]        res3_d, res3_q;
    logic [3:0]               flg3_d, flg3_q;

    // S1 unpack/classify intermediates
    logic                     sign_a, sign_b;
    logic [EXP_W-1:0]         exp_a, exp_b;
    logic [FRAC_W-1:0]        frac_a, frac_b;
    logic                     zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;

    // S3 normalise/round intermediates
    logic                     norm_shift;
    logic [PROD_W-1:0]        prod_n;
    logic signed [EXP_SW-1:0] exp_n, exp_f;
    logic [MANT_W-1:0]        mant_n;
    logic                     guard_bit, sticky_bit, round_up, carry, inexact;
    logic [MANT_W:0]          mant_r;
    logic [FRAC_W-1:0]        frac_r;

    assign adv      = !v3_q | OutReady;
    assign InReady  = adv;
    assign OutValid = v3_q;
    assign Result   = res3_q;
    assign Flags    = flg3_q;

    // S1: classify operands, flush subnormals, sum exponents, resolve specials.
    always_comb begin
        {sign_a, exp_a, frac_a} = Operand1;
        {sign_b, exp_b, frac_b} = Operand2;
        zero_a = (exp_a == '0);
        zero_b = (exp_b == '0);
        inf_a  = (&exp_a) & ~(|frac_a);
        inf_b  = (&exp_b) & ~(|frac_b);
        nan_a  = (&exp_a) & (|frac_a);
        nan_b  = (&exp_b) & (|frac_b);
        snan_a = nan_a & ~frac_a[FRAC_W-1];
        snan_b = nan_b & ~frac_b[FRAC_W-1];

        v1_d       = adv ? InValid : v1_q;
        sign1_d    = sign1_q;
        exp1_d     = exp1_q;
        mant_a1_d  = mant_a1_q;
        mant_b1_d  = mant_b1_q;
        spc1_d     = spc1_q;
        spc_res1_d = spc_res1_q;
        spc_flg1_d = spc_flg1_q;

        if (adv && InValid) begin
            sign1_d    = sign_a ^ sign_b;
            exp1_d     = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;
            mant_a1_d  = zero_a ? '0 : {1'b1, frac_a};
            mant_b1_d  = zero_b ? '0 : {1'b1, frac_b};
            spc1_d     = 1'b0;
            spc_res1_d = '0;
            spc_flg1_d = 4'b0000;
            if (nan_a || nan_b) begin
                spc1_d     = 1'b1;
                spc_res1_d = QNAN;
                spc_flg1_d = {snan_a | snan_b, 3'b000};
            end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
                spc1_d     = 1'b1;
                spc_res1_d = QNAN;
                spc_flg1_d = 4'b1000;
            end else if (inf_a || inf_b) begin
                spc1_d     = 1'b1;
                spc_res1_d = {sign_a ^ sign_b, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            end else if (zero_a || zero_b) begin
                spc1_d     = 1'b1;
                spc_res1_d = {sign_a ^ sign_b, {(DATA_W-1){1'b0}}};
            end
        end
    end

    // S2: full-width mantissa product; special-case info travels alongside.
    always_comb begin
        v2_d       = adv ? v1_q : v2_q;
        sign2_d    = sign2_q;
        exp2_d     = exp2_q;
        prod2_d    = prod2_q;
        spc2_d     = spc2_q;
        spc_res2_d = spc_res2_q;
        spc_flg2_d = spc_flg2_q;
        if (adv && v1_q) begin
            sign2_d    = sign1_q;
            exp2_d     = exp1_q;
            prod2_d    = {{MANT_W{1'b0}}, mant_a1_q} * {{MANT_W{1'b0}}, mant_b1_q};
            spc2_d     = spc1_q;
            spc_res2_d = spc_res1_q;
            spc_flg2_d = spc_flg1_q;
        end
    end

    // S3: normalise, round-to-nearest-even, range check, pack and flag.
    always_comb begin
        norm_shift = prod2_q[PROD_W-1];
        prod_n     = norm_shift ? prod2_q : (prod2_q << 1);
        exp_n      = exp2_q + (norm_shift ? EXP_SW'(1) : EXP_SW'(0));
        mant_n     = prod_n[PROD_W-1 -: MANT_W];
        guard_bit  = prod_n[PROD_W-MANT_W-1];
        sticky_bit = |prod_n[PROD_W-MANT_W-2:0];
        round_up   = guard_bit & (sticky_bit | mant_n[0]);
        mant_r     = {1'b0, mant_n} + {{MANT_W{1'b0}}, round_up};
        carry      = mant_r[MANT_W];
        frac_r     = carry ? mant_r[MANT_W-1:1] : mant_r[FRAC_W-1:0];
        exp_f      = exp_n + (carry ? EXP_SW'(1) : EXP_SW'(0));
        inexact    = guard_bit | sticky_bit;

        v3_d   = adv ? v2_q : v3_q;
        res3_d = res3_q;
        flg3_d = flg3_q;
        if (adv && v2_q) begin
            if (spc2_q) begin
                res3_d = spc_res2_q;
                flg3_d = spc_flg2_q;
            end else if (exp_f >= EMAX_S) begin
                res3_d = {sign2_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                flg3_d = 4'b0101;
            end else if (exp_f <= EXP_SW'(0)) begin
                res3_d = {sign2_q, {(DATA_W-1){1'b0}}};
                flg3_d = 4'b0011;
            end else begin
                res3_d = {sign2_q, exp_f[EXP_W-1:0], frac_r};
                flg3_d = {3'b000, inexact};
            end
        end
    end

    // Pipeline state registers; reset discards everything in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v1_q       <= 1'b0;
            sign1_q    <= 1'b0;
            exp1_q     <= '0;
            mant_a1_q  <= '0;
            mant_b1_q  <= '0;
            spc1_q     <= 1'b0;
            spc_res1_q <= '0;
            spc_flg1_q <= 4'b0000;
            v2_q       <= 1'b0;
            sign2_q    <= 1'b0;
            exp2_q     <= '0;
            prod2_q    <= '0;
            spc2_q     <= 1'b0;
            spc_res2_q <= '0;
            spc_flg2_q <= 4'b0000;
            v3_q       <= 1'b0;
            res3_q     <= '0;
            flg3_q     <= 4'b0000;
        end else begin
            v1_q       <= v1_d;
            sign1_q    <= sign1_d;
            exp1_q     <= exp1_d;
            mant_a1_q  <= mant_a1_d;
            mant_b1_q  <= mant_b1_d;
            spc1_q     <= spc1_d;
            spc_res1_q <= spc_res1_d;
            spc_flg1_q <= spc_flg1_d;
            v2_q       <= v2_d;
            sign2_q    <= sign2_d;
            exp2_q     <= exp2_d;
            prod2_q    <= prod2_d;
            spc2_q     <= spc2_d;
            spc_res2_q <= spc_res2_d;
            spc_flg2_q <= spc_flg2_d;
            v3_q       <= v3_d;
            res3_q     <= res3_d;
            flg3_q     <= flg3_d;
        end
    end

`ifdef FP_MUL_STICKY_FLAGS_EN
    logic [3:0] sticky_d, sticky_q;
    logic       out_hs;

    // Accumulate flags on each output handshake; a clear keeps only this cycle's flags.
    always_comb begin
        out_hs   = v3_q & OutReady;
        sticky_d = sticky_q;
        if (ClearFlags) begin
            sticky_d = out_hs ? flg3_q : 4'b0000;
        end else if (out_hs) begin
            sticky_d = sticky_q | flg3_q;
        end
    end

    // Sticky flag register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sticky_q <= 4'b0000;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign StickyFlags = sticky_q;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Testbench for fp_mul_pipe (single precision): vector table streamed through
// a scoreboard, plus hand-written latency, stall, reset and sticky sequences.
module tb_fp_mul_pipe;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flg;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
      int          id;
   } exp_t;

   localparam int NV = 20;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        InValid = 1'b0;
   logic        OutReady = 1'b1;
   logic [31:0] Operand1 = '0;
   logic [31:0] Operand2 = '0;
   logic        InReady;
   logic        OutValid;
   logic [31:0] Result;
   logic [3:0]  Flags;
`ifdef FP_MUL_STICKY_FLAGS_EN
   logic        ClearFlags = 1'b0;
   logic [3:0]  StickyFlags;
   logic [3:0]  stickyModel = 4'b0000;
`endif

   vec_t vecs [NV];
   exp_t sb [$];
   exp_t pending;
   int   checks = 0;
   int   failures = 0;
   int   readyDefault = 1;
   int   stallLeft = 0;
   logic stalledPrev = 1'b0;
   logic acc;

   fp_mul_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .InValid(InValid),
      .InReady(InReady),
      .Operand1(Operand1),
      .Operand2(Operand2),
      .OutValid(OutValid),
      .OutReady(OutReady),
      .Result(Result),
      .Flags(Flags)
`ifdef FP_MUL_STICKY_FLAGS_EN
      ,
      .ClearFlags(ClearFlags),
      .StickyFlags(StickyFlags)
`endif
   );

   // Free-running clock.
   always #5 CLK = ~CLK;

   // Hard stop so the bench can never hang.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog got timeout want finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s got %h want %h", name, act, req);
      end
   endtask

   // Pop the oldest expected result and compare it with the DUT output.
   task automatic checkOutput(output logic [3:0] ef);
      exp_t e;
      ef = 4'b0000;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL unexpected_output got %h want none", Result);
      end else begin
         e = sb.pop_front();
         check($sformatf("result[%0d]", e.id), Result, e.res);
         check($sformatf("flags[%0d]", e.id), {28'b0, Flags}, {28'b0, e.flg});
         ef = e.flg;
      end
   endtask

   // One clock cycle: drive OutReady, sample at the falling edge, advance.
   task automatic tick(output logic accepted);
      logic       hs;
      logic [3:0] hsFlags;
      if (stallLeft > 0) begin
         OutReady = 1'b0;
         stallLeft--;
      end else begin
         OutReady = (readyDefault != 0);
      end
      @(negedge CLK);
      if (stalledPrev) check("stall_hold_valid", {31'b0, OutValid}, 32'd1);
      if (OutValid && !OutReady) check("inready_stalled", {31'b0, InReady}, 32'd0);
      stalledPrev = OutValid && !OutReady;
      accepted = InValid && InReady;
      if (accepted) sb.push_back(pending);
      hs = OutValid && OutReady;
      hsFlags = 4'b0000;
      if (hs) checkOutput(hsFlags);
`ifdef FP_MUL_STICKY_FLAGS_EN
      check("sticky_flags", {28'b0, StickyFlags}, {28'b0, stickyModel});
      if (ClearFlags) stickyModel = hs ? hsFlags : 4'b0000;
      else if (hs) stickyModel = stickyModel | hsFlags;
`endif
      @(posedge CLK);
      #1;
   endtask

   // Present vector id and keep cycling until it is accepted.
   task automatic applyStimulus(input int id);
      logic a;
      Operand1 = vecs[id].a;
      Operand2 = vecs[id].b;
      InValid  = 1'b1;
      pending  = '{res: vecs[id].res, flg: vecs[id].flg, id: id};
      a = 1'b0;
      for (int n = 0; n < 60 && !a; n++) tick(a);
      checks++;
      if (!a) begin
         failures++;
         $display("[TB] FAIL accept_timeout[%0d] got 0 want 1", id);
      end
   endtask

   task automatic drain();
      logic a;
      InValid = 1'b0;
      for (int n = 0; n < 200 && (sb.size() != 0 || OutValid); n++) tick(a);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain_timeout got %0d want 0", sb.size());
      end
   endtask

   initial begin
      vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
      vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
      vecs[2]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101};
      vecs[3]  = '{32'hFF000000, 32'h7F000000, 32'hFF800000, 4'b0101};
      vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
      vecs[5]  = '{32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000};
      vecs[6]  = '{32'h7FC00001, 32'h40000000, 32'h7FC00000, 4'b0000};
      vecs[7]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};
      vecs[8]  = '{32'h00000001, 32'h7F000000, 32'h00000000, 4'b0000};
      vecs[9]  = '{32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0001};
      vecs[10] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001};
      vecs[11] = '{32'h3FCA6691, 32'h3FA1E58F, 32'h40000000, 4'b0001};
      vecs[12] = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000};
      vecs[13] = '{32'h7FC00000, 32'h7F800001, 32'h7FC00000, 4'b1000};
      vecs[14] = '{32'hFF800000, 32'h7F800000, 32'hFF800000, 4'b0000};
      vecs[15] = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000};
      vecs[16] = '{32'h00000001, 32'h7F800000, 32'h7FC00000, 4'b1000};
      vecs[17] = '{32'h7E800000, 32'h40000000, 32'h7F000000, 4'b0000};
      vecs[18] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000};
      vecs[19] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101};

      // Reset state
      repeat (3) @(posedge CLK);
      #1;
      check("reset_outvalid", {31'b0, OutValid}, 32'd0);
      check("reset_result", Result, 32'h0);
      check("reset_flags", {28'b0, Flags}, 32'h0);
      check("reset_inready", {31'b0, InReady}, 32'd1);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;

      // Latency: single op, OutValid in the third cycle after the accept edge
      OutReady = 1'b1;
      Operand1 = vecs[0].a;
      Operand2 = vecs[0].b;
      InValid  = 1'b1;
      @(negedge CLK);
      check("lat_inready", {31'b0, InReady}, 32'd1);
      @(posedge CLK);
      #1;
      InValid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge CLK);
         check($sformatf("lat_outvalid_c%0d", c), {31'b0, OutValid}, (c == 3) ? 32'd1 : 32'd0);
      end
      check("lat_result", Result, vecs[0].res);
      check("lat_flags", {28'b0, Flags}, {28'b0, vecs[0].flg});
      @(posedge CLK);
      #1;
      @(negedge CLK);
      check("lat_consumed", {31'b0, OutValid}, 32'd0);
      @(posedge CLK);
      #1;

      // Full table, back-to-back, consumer always ready
      $display("[TB] table stream");
      for (int i = 0; i < NV; i++) applyStimulus(i);
      drain();

      // Eight-op stream with a three-cycle consumer stall mid-stream
      $display("[TB] stall stream");
      for (int k = 0; k < 8; k++) begin
         if (k == 4) stallLeft = 3;
         applyStimulus(k);
      end
      drain();

      // Fill the pipe while stalled, then pulse reset asynchronously
      $display("[TB] reset pulse");
      readyDefault = 0;
      for (int k = 9; k < 12; k++) applyStimulus(k);
      InValid = 1'b0;
      tick(acc);
      tick(acc);
      check("pre_reset_outvalid", {31'b0, OutValid}, 32'd1);
      #2;
      RST_N = 1'b0;
      #1;
      check("async_reset_outvalid", {31'b0, OutValid}, 32'd0);
      check("async_reset_result", Result, 32'h0);
      check("async_reset_flags", {28'b0, Flags}, 32'h0);
      check("async_reset_inready", {31'b0, InReady}, 32'd1);
      sb.delete();
      stalledPrev = 1'b0;
`ifdef FP_MUL_STICKY_FLAGS_EN
      stickyModel = 4'b0000;
`endif
      #1;
      RST_N = 1'b1;
      readyDefault = 1;
      @(posedge CLK);
      #1;

      // Post-reset stream, with flag clears mid-stream when sticky flags exist
      $display("[TB] post-reset stream");
      for (int i = 0; i < NV; i++) begin
`ifdef FP_MUL_STICKY_FLAGS_EN
         ClearFlags = (i == 6 || i == 13);
`endif
         applyStimulus(i);
      end
`ifdef FP_MUL_STICKY_FLAGS_EN
      ClearFlags = 1'b0;
`endif
      drain();
`ifdef FP_MUL_STICKY_FLAGS_EN
      ClearFlags = 1'b1;
      tick(acc);
      ClearFlags = 1'b0;
      tick(acc);
      check("sticky_cleared", {28'b0, StickyFlags}, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
